// File: rtl/mac_result_serializer.sv
// -----------------------------------------------------------------------------
// mac_result_serializer
//
// Captures snapshots of NUM_CH signed MAC results into a DEPTH-entry FIFO and
// streams them out one channel at a time on a valid/ready interface. Output
// transfers are paced by a programmable minimum gap. A load that arrives
// while the FIFO is full is dropped and recorded in a sticky overflow flag.
//
// Ports:
//   clk         clock
//   reset       asynchronous, active-high reset
//   clear       synchronous flush of FIFO, pointers, channel, gap and overflow
//   load        capture request for prod_in
//   prod_in     NUM_CH packed signed results, channel k at [k*DATA_W +: DATA_W]
//   load_ready  FIFO not full (from registered count only)
//   gap         minimum cycles between output transfers (0 and 1: back-to-back)
//   out_data    signed result of the current channel of the head snapshot
//   out_ch      channel index of out_data
//   out_last    out_data is the last channel of its snapshot
//   out_valid   out_data valid
//   out_ready   consumer accepts out_data
//   fifo_count  number of snapshots held
//   overflow    sticky: a load was dropped
// -----------------------------------------------------------------------------
module mac_result_serializer #(
    parameter int DATA_W = 19,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    parameter int GAP_W  = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load,
    input  logic [NUM_CH*DATA_W-1:0] prod_in,
    output logic                     load_ready,
    input  logic [GAP_W-1:0]         gap,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     overflow
);

    // Snapshot storage. Kept in flops with a combinational head read so a
    // snapshot written in one cycle is presentable at the output the next.
    logic [NUM_CH*DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CH_W-1:0]  ch_reg, ch_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             overflow_reg, overflow_next;

    logic push;
    logic drop;
    logic xfer;
    logic pop;

    // Full/empty come from the count, never from pointer comparison, since
    // the pointers are equal both when empty and when full.
    assign load_ready = (count_reg != CNT_W'(DEPTH));
    assign out_valid  = (count_reg != '0) && (gap_cnt_reg == '0);
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
    assign out_ch     = ch_reg;

    // clear outranks everything, including a coincident load or transfer.
    assign push = load && load_ready && !clear;
    assign drop = load && !load_ready && !clear;
    assign xfer = out_valid && out_ready && !clear;
    assign pop  = xfer && out_last;

    // Split the head snapshot into per-channel slices.
    logic [DATA_W-1:0] head_ch [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_head_slice
            assign head_ch[gi] = mem[rd_ptr_reg][gi*DATA_W +: DATA_W];
        end

        if (NUM_CH == 1) begin : g_single_ch
            assign out_data = head_ch[0];
            assign out_last = 1'b1;
        end else begin : g_multi_ch
            assign out_data = head_ch[ch_reg];
            assign out_last = (ch_reg == CH_W'(NUM_CH - 1));
        end
    endgenerate

    // Data storage carries no reset; contents are only observed while the
    // count says the entry is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= prod_in;
        end
    end

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        ch_next       = ch_reg;
        gap_cnt_next  = gap_cnt_reg;
        overflow_next = overflow_reg;

        if (clear) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            ch_next       = '0;
            gap_cnt_next  = '0;
            overflow_next = 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase

            if (drop) begin
                overflow_next = 1'b1;
            end

            // gap is sampled only on a transfer; the counter then runs down
            // regardless of out_ready. Loading gap-1 leaves gap-1 idle cycles.
            if (xfer) begin
                gap_cnt_next = (gap == '0) ? '0 : gap - GAP_W'(1);
            end else if (gap_cnt_reg != '0) begin
                gap_cnt_next = gap_cnt_reg - GAP_W'(1);
            end

            if (xfer) begin
                ch_next = out_last ? '0 : ch_reg + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ch_reg       <= '0;
            gap_cnt_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            ch_reg       <= ch_next;
            gap_cnt_reg  <= gap_cnt_next;
            overflow_reg <= overflow_next;
        end
    end

endmodule

// File: tb/tb_mac_result_serializer.sv
module tb_mac_result_serializer;

    localparam int DATA_W = 19;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;
    localparam int GAP_W  = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     clear;
    logic                     load;
    logic [NUM_CH*DATA_W-1:0] prod_in;
    logic                     load_ready;
    logic [GAP_W-1:0]         gap;
    logic [DATA_W-1:0]        out_data;
    logic [0:0]               out_ch;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [2:0]               fifo_count;
    logic                     overflow;

    mac_result_serializer #(
        .DATA_W(DATA_W),
        .NUM_CH(NUM_CH),
        .DEPTH (DEPTH),
        .GAP_W (GAP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (load),
        .prod_in   (prod_in),
        .load_ready(load_ready),
        .gap       (gap),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ch;
        logic              last;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_cyc_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every accepted output beat is compared with the oldest
    // expected beat queued by the stimulus.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            xfer_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got data=%0d ch=%0d, required no transfer (cycle %0d)",
                         $signed(out_data), out_ch, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", $signed(out_data), $signed(mon_e.data));
                check("out_ch",   int'(out_ch),      int'(mon_e.ch));
                check("out_last", int'(out_last),    int'(mon_e.last));
                $display("xfer cycle=%0d data=%0d ch=%0d last=%0d",
                         cyc, $signed(out_data), out_ch, out_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int d0, input int d1, input bit accept);
        prod_in = {DATA_W'(d1), DATA_W'(d0)};
        load    = 1'b1;
        if (accept) begin
            exp_q.push_back('{data: DATA_W'(d0), ch: 1'b0, last: 1'b0});
            exp_q.push_back('{data: DATA_W'(d1), ch: 1'b1, last: 1'b1});
        end
        $display("load ch0=%0d ch1=%0d expect_accept=%0d", d0, d1, accept);
        tick();
        load = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) begin
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d beats outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required self-termination");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        load      = 1'b0;
        prod_in   = '0;
        gap       = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_out_valid",  int'(out_valid),  0);
        check("rst_load_ready", int'(load_ready), 1);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_overflow",   int'(overflow),   0);

        // Single snapshot, gap 0: valid one cycle after load, two beats
        out_ready = 1'b1;
        do_load(7, -5, 1);
        check("load_to_valid", int'(out_valid), 1);
        tick();
        tick();
        check("t1_fifo_count", int'(fifo_count), 0);
        check("t1_out_valid",  int'(out_valid),  0);

        // Pacing: gap 4 gives transfers every 4 cycles
        xfer_cyc_q.delete();
        gap = 4'd4;
        do_load(1, 2, 1);
        do_load(3, 4, 1);
        for (int i = 0; i < 60 && xfer_cyc_q.size() < 4; i++) tick();
        check("gap_xfer_count", xfer_cyc_q.size(), 4);
        if (xfer_cyc_q.size() >= 4) begin
            for (int i = 1; i < 4; i++) begin
                check("gap_spacing", xfer_cyc_q[i] - xfer_cyc_q[i-1], 4);
            end
        end
        gap = '0;
        repeat (4) tick();
        check("gap_fifo_count", int'(fifo_count), 0);

        // Fill with out_ready low, overflow on 5th load, drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_load(10 + i, -(20 + i), 1);
        check("full_load_ready", int'(load_ready), 0);
        check("full_fifo_count", int'(fifo_count), 4);
        check("full_overflow",   int'(overflow),   0);
        do_load(999, -999, 0);
        check("ovf_set",        int'(overflow),   1);
        check("ovf_fifo_count", int'(fifo_count), 4);
        out_ready = 1'b1;
        wait_drain("ovf_drain", 40);
        tick();
        check("ovf_sticky",      int'(overflow),   1);
        check("drain_fifo_count", int'(fifo_count), 0);
        clear_pulse();
        check("clear_overflow",   int'(overflow),   0);
        check("clear_load_ready", int'(load_ready), 1);

        // Load while full on the cycle the last channel pops is dropped
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_load(30 + i, -(40 + i), 1);
        out_ready = 1'b1;
        tick();
        do_load(77, -77, 0);
        check("popcyc_overflow",   int'(overflow),   1);
        check("popcyc_fifo_count", int'(fifo_count), 3);
        do_load(88, -88, 1);
        check("refill_fifo_count", int'(fifo_count), 4);
        wait_drain("popcyc_drain", 40);
        clear_pulse();

        // Three fill/drain rounds to exercise pointer wrap
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0;
            for (int i = 0; i < 4; i++) do_load(100 * (r + 1) + i, -(100 * (r + 1) + 50 + i), 1);
            check("wrap_full_count", int'(fifo_count), 4);
            check("wrap_load_ready", int'(load_ready), 0);
            out_ready = 1'b1;
            wait_drain("wrap_drain", 40);
            check("wrap_empty_count", int'(fifo_count), 0);
        end

        // Stall between channels holds the presented beat
        out_ready = 1'b0;
        do_load(11, -22, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", int'(out_valid),          1);
            check("stall_data",  $signed(out_data),        -22);
            check("stall_ch",    int'(out_ch),             1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("stall_pop_count", int'(fifo_count), 0);
        check("stall_pop_valid", int'(out_valid),  0);

        // Asynchronous reset mid-snapshot
        out_ready = 1'b0;
        do_load(100, 200, 1);
        do_load(300, 400, 1);
        out_ready = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid",  int'(out_valid),  0);
        check("arst_fifo_count", int'(fifo_count), 0);
        check("arst_overflow",   int'(overflow),   0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_valid", int'(out_valid), 0);
        do_load(55, -66, 1);
        wait_drain("post_rst_drain", 20);
        tick();
        check("post_rst_count", int'(fifo_count), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
